// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory wait/timeout, forwarding.
// Optional perf counters (stallCycles, flushCount) are built when HAZ_CTRL_PERF_EN is defined.
module hazard_ctrl #(
   parameter int unsigned REG_BITS    = 5,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_BITS-1:0] idRs,
   input  logic [REG_BITS-1:0] idRt,
   input  logic                idUsesRt,
   input  logic [REG_BITS-1:0] exRs,
   input  logic [REG_BITS-1:0] exRt,
   input  logic [REG_BITS-1:0] exRd,
   input  logic                exRegWrite,
   input  logic                exMemRead,
   input  logic [REG_BITS-1:0] memRd,
   input  logic                memRegWrite,
   input  logic [REG_BITS-1:0] wbRd,
   input  logic                wbRegWrite,
   input  logic                branchTaken,
   input  logic                memReq,
   input  logic                memReady,
   output logic                stallIF,
   output logic                stallID,
   output logic                stallEX,
   output logic                stallMEM,
   output logic                flushID,
   output logic                flushEX,
   output logic [1:0]          fwdA,
   output logic [1:0]          fwdB,
   output logic                memErr
`ifdef HAZ_CTRL_PERF_EN
   ,
   output logic [31:0]         stallCycles,
   output logic [15:0]         flushCount
`endif
);

   localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
   logic                mem_err_q, mem_err_d;

   logic                load_use;
   logic                stall_all, stall_lu, flush_id, flush_ex;

   function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src);
      if (memRegWrite && (memRd != '0) && (memRd == src)) begin
         return 2'b01;
      end else if (wbRegWrite && (wbRd != '0) && (wbRd == src)) begin
         return 2'b10;
      end
      return 2'b00;
   endfunction

   assign load_use = exMemRead && exRegWrite && (exRd != '0) &&
                     ((exRd == idRs) || (idUsesRt && (exRd == idRt)));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      stall_all  = 1'b0;
      stall_lu   = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      unique case (state_q)
         StRun: begin
            if (memReq && !memReady) begin
               stall_all  = 1'b1;
               state_d    = StMemWait;
               wait_cnt_d = CntW'(1);
            end else if (branchTaken) begin
               flush_id = 1'b1;
               flush_ex = 1'b1;
            end else if (load_use) begin
               stall_lu = 1'b1;
               flush_ex = 1'b1;
            end
         end
         StMemWait: begin
            if (memReady) begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end else begin
               stall_all = 1'b1;
               if (wait_cnt_q == CntW'(MEM_TIMEOUT)) begin
                  state_d = StErr;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
         end
         StErr: begin
            stall_all = 1'b1;
         end
         default: begin
            state_d    = StRun;
            wait_cnt_d = '0;
         end
      endcase
      mem_err_d = (state_d == StErr);
   end

   // Every output is held low while reset is asserted.
   always_comb begin
      stallIF  = reset & (stall_all | stall_lu);
      stallID  = reset & (stall_all | stall_lu);
      stallEX  = reset & stall_all;
      stallMEM = reset & stall_all;
      flushID  = reset & flush_id;
      flushEX  = reset & flush_ex;
      fwdA     = reset ? fwd_sel(exRs) : 2'b00;
      fwdB     = reset ? fwd_sel(exRt) : 2'b00;
      memErr   = reset & mem_err_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

`ifdef HAZ_CTRL_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (stallIF && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if ((flushID || flushEX) && (flush_count_q != '1)) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign stallCycles = stall_cycles_q;
   assign flushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues hand-computed outputs, a negedge monitor checks them.
module tb_hazard_ctrl;

   localparam int unsigned RB = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [RB-1:0] idRs, idRt, exRs, exRt, exRd, memRd, wbRd;
   logic          idUsesRt, exRegWrite, exMemRead, memRegWrite, wbRegWrite;
   logic          branchTaken, memReq, memReady;
   logic          stallIF, stallID, stallEX, stallMEM, flushID, flushEX, memErr;
   logic [1:0]    fwdA, fwdB;
`ifdef HAZ_CTRL_PERF_EN
   logic [31:0]   stallCycles;
   logic [15:0]   flushCount;
`endif

   int n_checks = 0;
   int n_errors = 0;

   string         qn[$];
   logic [10:0]   qe[$];

   hazard_ctrl #(.REG_BITS(RB), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
      .exRs(exRs), .exRt(exRt), .exRd(exRd), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
      .memRd(memRd), .memRegWrite(memRegWrite), .wbRd(wbRd), .wbRegWrite(wbRegWrite),
      .branchTaken(branchTaken), .memReq(memReq), .memReady(memReady),
      .stallIF(stallIF), .stallID(stallID), .stallEX(stallEX), .stallMEM(stallMEM),
      .flushID(flushID), .flushEX(flushEX), .fwdA(fwdA), .fwdB(fwdB), .memErr(memErr)
`ifdef HAZ_CTRL_PERF_EN
      , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
   );

   always #5 clk = ~clk;

   // Packed as {stallIF, stallID, stallEX, stallMEM, flushID, flushEX, fwdA, fwdB, memErr}.
   function automatic logic [10:0] mk(input logic [3:0] st, input logic [1:0] fl,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic err);
      return {st, fl, fa, fb, err};
   endfunction

   localparam logic [3:0] S0 = 4'b0000, SLU = 4'b1100, SALL = 4'b1111;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic [10:0] e);
      qn.push_back(nm);
      qe.push_back(e);
   endtask

   task automatic idle();
      idRs = '0; idRt = '0; idUsesRt = 1'b0;
      exRs = '0; exRt = '0; exRd = '0; exRegWrite = 1'b0; exMemRead = 1'b0;
      memRd = '0; memRegWrite = 1'b0; wbRd = '0; wbRegWrite = 1'b0;
      branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
   endtask

   task automatic load_use_rs(input logic [RB-1:0] r);
      exMemRead = 1'b1; exRegWrite = 1'b1; exRd = r; idRs = r;
   endtask

   // Monitor: compares every queued expectation against the live outputs mid-cycle.
   always @(negedge clk) begin
      logic [10:0] act, e;
      string       nm;
      act = {stallIF, stallID, stallEX, stallMEM, flushID, flushEX, fwdA, fwdB, memErr};
      while (qe.size() > 0) begin
         e  = qe.pop_front();
         nm = qn.pop_front();
         n_checks++;
         if (act !== e) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, e);
         end
      end
   end

   initial begin
      idle();
      reset = 1'b0;
      #1;
      // Reset forces outputs low even with active inputs.
      branchTaken = 1'b1; memReq = 1'b1; exRs = 5'd3; memRd = 5'd3; memRegWrite = 1'b1;
      load_use_rs(5'd5);
      expect_out("reset_force", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); nxt();
      reset = 1'b1; idle();
      expect_out("idle", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));

      nxt(); load_use_rs(5'd5);
      expect_out("load_use", mk(SLU, 2'b01, 2'b00, 2'b00, 1'b0));
      nxt(); idle();
      expect_out("bubble_once", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); load_use_rs(5'd0);
      expect_out("load_use_r0", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); idle(); exMemRead = 1'b1; exRegWrite = 1'b1; exRd = 5'd7; idRt = 5'd7;
      idRs = 5'd1; idUsesRt = 1'b1;
      expect_out("load_use_rt", mk(SLU, 2'b01, 2'b00, 2'b00, 1'b0));
      nxt(); idUsesRt = 1'b0;
      expect_out("rt_unused", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); idUsesRt = 1'b1; exRegWrite = 1'b0;
      expect_out("no_regwrite", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));

      nxt(); idle(); exRs = 5'd3; memRd = 5'd3; wbRd = 5'd3; memRegWrite = 1'b1; wbRegWrite = 1'b1;
      expect_out("fwd_mem_prio", mk(S0, 2'b00, 2'b01, 2'b00, 1'b0));
      nxt(); memRegWrite = 1'b0;
      expect_out("fwd_wb", mk(S0, 2'b00, 2'b10, 2'b00, 1'b0));
      nxt(); exRt = 5'd3; exRs = 5'd4; memRegWrite = 1'b1; memRd = 5'd4;
      expect_out("fwd_split", mk(S0, 2'b00, 2'b01, 2'b10, 1'b0));
      nxt(); exRs = 5'd0; exRt = 5'd0; memRd = 5'd0; wbRd = 5'd0;
      expect_out("fwd_r0", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));

      nxt(); idle(); load_use_rs(5'd6); branchTaken = 1'b1;
      expect_out("branch_over_lu", mk(S0, 2'b11, 2'b00, 2'b00, 1'b0));

      // Four cycles of wait, branch asserted throughout, then release.
      nxt(); idle(); memReq = 1'b1; branchTaken = 1'b1;
      expect_out("wait_c1", mk(SALL, 2'b00, 2'b00, 2'b00, 1'b0));
      for (int i = 2; i <= 4; i++) begin
         nxt();
         expect_out($sformatf("wait_c%0d", i), mk(SALL, 2'b00, 2'b00, 2'b00, 1'b0));
      end
      nxt(); memReady = 1'b1;
      expect_out("wait_release", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); memReq = 1'b0; memReady = 1'b0;
      expect_out("run_after_wait", mk(S0, 2'b11, 2'b00, 2'b00, 1'b0));

      nxt(); idle(); memReq = 1'b1; memReady = 1'b1;
      expect_out("zero_wait", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); idle(); branchTaken = 1'b1;
      expect_out("zero_wait_run", mk(S0, 2'b11, 2'b00, 2'b00, 1'b0));

      // Wait resolved exactly when waitCnt == MEM_TIMEOUT.
      nxt(); idle(); memReq = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         expect_out($sformatf("edge_wait_%0d", i), mk(SALL, 2'b00, 2'b00, 2'b00, 1'b0));
         nxt();
      end
      memReady = 1'b1;
      expect_out("edge_release", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); idle(); branchTaken = 1'b1;
      expect_out("edge_no_err", mk(S0, 2'b11, 2'b00, 2'b00, 1'b0));

      // Timeout: nine stalled cycles, then ERR.
      nxt(); idle(); memReq = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         expect_out($sformatf("to_stall_%0d", i), mk(SALL, 2'b00, 2'b00, 2'b00, 1'b0));
         nxt();
      end
      expect_out("to_err", mk(SALL, 2'b00, 2'b00, 2'b00, 1'b1));
      nxt(); memReq = 1'b0; memReady = 1'b1; branchTaken = 1'b1;
      exRs = 5'd3; memRd = 5'd3; memRegWrite = 1'b1;
      expect_out("err_sticky", mk(SALL, 2'b00, 2'b01, 2'b00, 1'b1));
      nxt(); reset = 1'b0;
      expect_out("err_reset", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); reset = 1'b1; idle();
      expect_out("after_reset", mk(S0, 2'b00, 2'b00, 2'b00, 1'b0));
      nxt(); branchTaken = 1'b1;
      expect_out("after_reset_run", mk(S0, 2'b11, 2'b00, 2'b00, 1'b0));

`ifdef HAZ_CTRL_PERF_EN
      nxt(); idle(); reset = 1'b0;
      nxt(); reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         load_use_rs(5'd9);
         nxt(); idle();
         nxt();
      end
      branchTaken = 1'b1;
      nxt(); idle();
      nxt();
      n_checks++;
      if (stallCycles !== 32'd3) begin
         n_errors++;
         $display("FAIL perf_stall: got %0d expected 3", stallCycles);
      end
      n_checks++;
      if (flushCount !== 16'd4) begin
         n_errors++;
         $display("FAIL perf_flush: got %0d expected 4", flushCount);
      end
`endif

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
